// File: rtl/ram_port_arbiter_if.sv
// Bundle of requester handshakes and RAM port-0 signals for ram_port_arbiter.
// The arbiter uses the slave view; requesters and the RAM sit on the master side.
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  req_a, req_b;
  logic                  we_a, we_b;
  logic [ADDR_WIDTH-1:0] addr_a, addr_b;
  logic [DATA_WIDTH-1:0] wdata_a, wdata_b;
  logic                  gnt_a, gnt_b;
  logic [DATA_WIDTH-1:0] rdata_a, rdata_b;
  logic                  rvalid_a, rvalid_b;
  logic                  busy;
  logic                  ram_cs, ram_we, ram_oe;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_wdrive;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, ram_rdata,
    output gnt_a, gnt_b, rdata_a, rdata_b, rvalid_a, rvalid_b, busy,
           ram_cs, ram_we, ram_oe, ram_addr, ram_wdata, ram_wdrive
  );

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, ram_rdata,
    input  gnt_a, gnt_b, rdata_a, rdata_b, rvalid_a, rvalid_b, busy,
           ram_cs, ram_we, ram_oe, ram_addr, ram_wdata, ram_wdrive
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter and access sequencer for port 0 of the display RAM.
// Writes take ACCESS only; reads add HOLD to wait out the RAM's registered read.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input logic               clk,
  input logic               reset_n,
  ram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  typedef struct packed {
    logic                  cs;
    logic                  we;
    logic                  oe;
    logic                  wdrive;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } ram_ctl_t;

  state_t                r_state, w_state_nxt;
  ram_ctl_t              r_ram, w_ram_nxt;
  logic                  r_last, w_last_nxt;   // 1 = B was served last
  logic                  r_sel, w_sel_nxt;     // 1 = B owns the current access
  logic                  r_gnt_a, w_gnt_a_nxt, r_gnt_b, w_gnt_b_nxt;
  logic                  r_rvalid_a, w_rvalid_a_nxt, r_rvalid_b, w_rvalid_b_nxt;
  logic [DATA_WIDTH-1:0] r_rdata_a, w_rdata_a_nxt, r_rdata_b, w_rdata_b_nxt;
  logic                  w_win_b;
  logic                  w_we_sel;

  assign w_win_b  = bus.req_b & (~bus.req_a | ~r_last);
  assign w_we_sel = w_win_b ? bus.we_b : bus.we_a;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_ram      <= '0;
      r_last     <= 1'b1;
      r_sel      <= 1'b0;
      r_gnt_a    <= 1'b0;
      r_gnt_b    <= 1'b0;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ram      <= w_ram_nxt;
      r_last     <= w_last_nxt;
      r_sel      <= w_sel_nxt;
      r_gnt_a    <= w_gnt_a_nxt;
      r_gnt_b    <= w_gnt_b_nxt;
      r_rvalid_a <= w_rvalid_a_nxt;
      r_rvalid_b <= w_rvalid_b_nxt;
      r_rdata_a  <= w_rdata_a_nxt;
      r_rdata_b  <= w_rdata_b_nxt;
    end
  end

  // NOTE: every signal gets a default before the case, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_ram_nxt      = '0;
    w_last_nxt     = r_last;
    w_sel_nxt      = r_sel;
    w_gnt_a_nxt    = 1'b0;
    w_gnt_b_nxt    = 1'b0;
    w_rvalid_a_nxt = 1'b0;
    w_rvalid_b_nxt = 1'b0;
    w_rdata_a_nxt  = r_rdata_a;
    w_rdata_b_nxt  = r_rdata_b;

    case (r_state)
      IDLE: begin
        if (bus.req_a || bus.req_b) begin
          w_state_nxt      = ACCESS;
          w_last_nxt       = w_win_b;
          w_sel_nxt        = w_win_b;
          w_gnt_a_nxt      = ~w_win_b;
          w_gnt_b_nxt      = w_win_b;
          w_ram_nxt.cs     = 1'b1;
          w_ram_nxt.we     = w_we_sel;
          w_ram_nxt.oe     = ~w_we_sel;
          w_ram_nxt.wdrive = w_we_sel;
          w_ram_nxt.addr   = w_win_b ? bus.addr_b : bus.addr_a;
          w_ram_nxt.wdata  = w_win_b ? bus.wdata_b : bus.wdata_a;
        end
      end
      ACCESS: begin
        if (r_ram.we) begin
          w_state_nxt = IDLE;
        end else begin
          // Keep the read addressed while the RAM presents its registered data.
          w_state_nxt    = HOLD;
          w_ram_nxt.cs   = 1'b1;
          w_ram_nxt.oe   = 1'b1;
          w_ram_nxt.addr = r_ram.addr;
        end
      end
      HOLD: begin
        w_state_nxt = IDLE;
        if (r_sel) begin
          w_rdata_b_nxt  = bus.ram_rdata;
          w_rvalid_b_nxt = 1'b1;
        end else begin
          w_rdata_a_nxt  = bus.ram_rdata;
          w_rvalid_a_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.gnt_a      = r_gnt_a;
  assign bus.gnt_b      = r_gnt_b;
  assign bus.rvalid_a   = r_rvalid_a;
  assign bus.rvalid_b   = r_rvalid_b;
  assign bus.rdata_a    = r_rdata_a;
  assign bus.rdata_b    = r_rdata_b;
  assign bus.busy       = (r_state != IDLE);
  assign bus.ram_cs     = r_ram.cs;
  assign bus.ram_we     = r_ram.we;
  assign bus.ram_oe     = r_ram.oe;
  assign bus.ram_wdrive = r_ram.wdrive;
  assign bus.ram_addr   = r_ram.addr;
  assign bus.ram_wdata  = r_ram.wdata;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a registered-read RAM model on port 0.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_ram_port_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic [7:0] rd_reg;

  ram_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: write at the edge with cs&we, load read register with cs&~we.
  always @(posedge clk) begin
    if (bus.ram_cs && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_cs && !bus.ram_we) rd_reg <= mem[bus.ram_addr];
  end
  assign bus.ram_rdata = bus.ram_oe ? rd_reg : 8'h00;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [8:0] ctl;
    reset_n = 1'b0;
    bus.req_a = 0; bus.req_b = 0; bus.we_a = 0; bus.we_b = 0;
    bus.addr_a = '0; bus.addr_b = '0; bus.wdata_a = '0; bus.wdata_b = '0;
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();
    ctl = {bus.gnt_a, bus.gnt_b, bus.rvalid_a, bus.rvalid_b, bus.busy,
           bus.ram_cs, bus.ram_we, bus.ram_oe, bus.ram_wdrive};
    total++;
    if (ctl !== 9'b0) begin bad++; $display("FAIL reset_ctl got %b exp 000000000", ctl); end
    total++;
    if ({bus.ram_addr, bus.ram_wdata, bus.rdata_a, bus.rdata_b} !== 32'h0) begin
      bad++; $display("FAIL reset_data got %h exp 00000000",
                      {bus.ram_addr, bus.ram_wdata, bus.rdata_a, bus.rdata_b});
    end
  endtask

  task automatic test_write_read();
    bus.req_a = 1; bus.we_a = 1; bus.addr_a = 8'h10; bus.wdata_a = 8'h5A;
    cyc();
    total++;
    if ({bus.gnt_a, bus.gnt_b, bus.busy, bus.ram_cs, bus.ram_we, bus.ram_oe, bus.ram_wdrive} !== 7'b1011101) begin
      bad++; $display("FAIL wr_ctl got %b exp 1011101",
                      {bus.gnt_a, bus.gnt_b, bus.busy, bus.ram_cs, bus.ram_we, bus.ram_oe, bus.ram_wdrive});
    end
    total++;
    if ({bus.ram_addr, bus.ram_wdata} !== 16'h105A) begin
      bad++; $display("FAIL wr_addr_data got %h exp 105a", {bus.ram_addr, bus.ram_wdata});
    end
    bus.req_a = 0;
    cyc();
    total++;
    if ({bus.busy, bus.ram_cs, bus.gnt_a} !== 3'b000) begin
      bad++; $display("FAIL wr_done got %b exp 000", {bus.busy, bus.ram_cs, bus.gnt_a});
    end
    ref_mem[8'h10] = 8'h5A;
    bus.req_b = 1; bus.we_b = 0; bus.addr_b = 8'h10;
    cyc();
    total++;
    if ({bus.gnt_b, bus.ram_cs, bus.ram_oe, bus.ram_we, bus.ram_wdrive} !== 5'b11100) begin
      bad++; $display("FAIL rd_access got %b exp 11100",
                      {bus.gnt_b, bus.ram_cs, bus.ram_oe, bus.ram_we, bus.ram_wdrive});
    end
    bus.req_b = 0;
    cyc();
    total++;
    if ({bus.gnt_b, bus.busy, bus.ram_oe, bus.ram_addr, bus.rvalid_b} !== 12'b011_0001_0000_0) begin
      bad++; $display("FAIL rd_hold got %b exp 011000100000",
                      {bus.gnt_b, bus.busy, bus.ram_oe, bus.ram_addr, bus.rvalid_b});
    end
    cyc();
    total++;
    if ({bus.rvalid_b, bus.rvalid_a, bus.ram_oe, bus.busy} !== 4'b1000) begin
      bad++; $display("FAIL rd_valid got %b exp 1000", {bus.rvalid_b, bus.rvalid_a, bus.ram_oe, bus.busy});
    end
    total++;
    if (bus.rdata_b !== 8'h5A) begin bad++; $display("FAIL rd_data got %h exp 5a", bus.rdata_b); end
    cyc();
    total++;
    if ({bus.rvalid_b, bus.rdata_b} !== 9'h05A) begin
      bad++; $display("FAIL rd_hold_data got %h exp 05a", {bus.rvalid_b, bus.rdata_b});
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    bus.req_a = 1; bus.we_a = 1; bus.addr_a = 8'h20; bus.wdata_a = 8'hA0;
    bus.req_b = 1; bus.we_b = 1; bus.addr_b = 8'h21; bus.wdata_b = 8'hB0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      exp_g = (i % 2 == 0) ? 2'b00 : ((i % 4 == 1) ? 2'b10 : 2'b01);
      total++;
      if ({bus.gnt_a, bus.gnt_b} !== exp_g) begin
        bad++; $display("FAIL rr_cycle%0d got %b exp %b", i, {bus.gnt_a, bus.gnt_b}, exp_g);
      end
    end
    bus.req_a = 0; bus.req_b = 0;
    ref_mem[8'h20] = 8'hA0;
    ref_mem[8'h21] = 8'hB0;
    cyc();
  endtask

  task automatic test_back_to_back();
    mem[8'h01] <= 8'h11;
    mem[8'h02] <= 8'h22;
    ref_mem[8'h01] = 8'h11;
    ref_mem[8'h02] = 8'h22;
    bus.req_a = 1; bus.we_a = 0; bus.addr_a = 8'h01;
    for (int i = 1; i <= 7; i++) begin
      cyc();
      if (i == 1) bus.addr_a = 8'h02;
      if (i == 4) bus.req_a = 0;
      total++;
      if ({bus.rvalid_a, bus.rvalid_b, bus.gnt_b} !== {(i == 3 || i == 6), 2'b00}) begin
        bad++; $display("FAIL b2b_valid_cycle%0d got %b exp %b", i,
                        {bus.rvalid_a, bus.rvalid_b, bus.gnt_b}, {(i == 3 || i == 6), 2'b00});
      end
      if (i == 3) begin
        total++;
        if (bus.rdata_a !== 8'h11) begin bad++; $display("FAIL b2b_data1 got %h exp 11", bus.rdata_a); end
      end
      if (i == 6) begin
        total++;
        if (bus.rdata_a !== 8'h22) begin bad++; $display("FAIL b2b_data2 got %h exp 22", bus.rdata_a); end
      end
    end
  endtask

  task automatic test_mid_read_reset();
    bus.req_b = 1; bus.we_b = 0; bus.addr_b = 8'h10;
    cyc();
    total++;
    if (bus.gnt_b !== 1'b1) begin bad++; $display("FAIL mrr_gnt got %b exp 1", bus.gnt_b); end
    bus.req_b = 0;
    cyc();
    total++;
    if ({bus.busy, bus.ram_oe} !== 2'b11) begin bad++; $display("FAIL mrr_hold got %b exp 11", {bus.busy, bus.ram_oe}); end
    reset_n = 1'b0;
    cyc();
    total++;
    if ({bus.busy, bus.rvalid_b, bus.rvalid_a, bus.ram_cs, bus.ram_oe, bus.ram_we, bus.gnt_a, bus.gnt_b} !== 8'b0) begin
      bad++; $display("FAIL mrr_outputs got %b exp 00000000",
                      {bus.busy, bus.rvalid_b, bus.rvalid_a, bus.ram_cs, bus.ram_oe, bus.ram_we, bus.gnt_a, bus.gnt_b});
    end
    total++;
    if ({bus.rdata_b, bus.ram_addr} !== 16'h0) begin
      bad++; $display("FAIL mrr_data got %h exp 0000", {bus.rdata_b, bus.ram_addr});
    end
    reset_n = 1'b1;
    bus.req_a = 1; bus.we_a = 1; bus.addr_a = 8'h30; bus.wdata_a = 8'hC3;
    bus.req_b = 1; bus.we_b = 1; bus.addr_b = 8'h31; bus.wdata_b = 8'hD4;
    cyc();
    total++;
    if ({bus.gnt_a, bus.gnt_b, bus.rvalid_b} !== 3'b100) begin
      bad++; $display("FAIL mrr_first_gnt got %b exp 100", {bus.gnt_a, bus.gnt_b, bus.rvalid_b});
    end
    bus.req_a = 0;
    cyc();
    cyc();
    total++;
    if ({bus.gnt_a, bus.gnt_b} !== 2'b01) begin
      bad++; $display("FAIL mrr_second_gnt got %b exp 01", {bus.gnt_a, bus.gnt_b});
    end
    bus.req_b = 0;
    ref_mem[8'h30] = 8'hC3;
    ref_mem[8'h31] = 8'hD4;
    cyc();
  endtask

  task automatic test_late_request();
    bus.req_a = 1; bus.we_a = 1; bus.addr_a = 8'h40; bus.wdata_a = 8'h44;
    cyc();
    bus.req_a = 0;
    bus.req_b = 1; bus.we_b = 0; bus.addr_b = 8'h40;
    ref_mem[8'h40] = 8'h44;
    cyc();
    total++;
    if ({bus.busy, bus.gnt_b} !== 2'b00) begin bad++; $display("FAIL late_idle got %b exp 00", {bus.busy, bus.gnt_b}); end
    cyc();
    total++;
    if ({bus.gnt_b, bus.busy} !== 2'b11) begin bad++; $display("FAIL late_gnt got %b exp 11", {bus.gnt_b, bus.busy}); end
    bus.req_b = 0;
    cyc();
    cyc();
    total++;
    if ({bus.rvalid_b, bus.rdata_b} !== 9'h144) begin
      bad++; $display("FAIL late_rdata got %h exp 144", {bus.rvalid_b, bus.rdata_b});
    end
  endtask

  task automatic test_random_protocol();
    logic       sel, we, got;
    logic [7:0] addr, wd;
    for (int n = 0; n < 200; n++) begin
      sel  = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      addr = 8'($urandom_range(0, 15));
      wd   = 8'($urandom);
      if (sel) begin bus.req_b = 1; bus.we_b = we; bus.addr_b = addr; bus.wdata_b = wd; end
      else     begin bus.req_a = 1; bus.we_a = we; bus.addr_a = addr; bus.wdata_a = wd; end
      got = 1'b0;
      for (int k = 0; k < 6 && !got; k++) begin
        cyc();
        total += 2;
        if ((bus.ram_we & bus.ram_oe) !== 1'b0) begin bad++; $display("FAIL rnd_we_oe op%0d got 1 exp 0", n); end
        if (bus.ram_wdrive !== (bus.ram_cs & bus.ram_we)) begin
          bad++; $display("FAIL rnd_wdrive op%0d got %b exp %b", n, bus.ram_wdrive, bus.ram_cs & bus.ram_we);
        end
        if ((sel ? bus.gnt_b : bus.gnt_a) === 1'b1) got = 1'b1;
      end
      total++;
      if (!got) begin bad++; $display("FAIL rnd_gnt op%0d got timeout exp grant", n); end
      bus.req_a = 0; bus.req_b = 0;
      if (we) ref_mem[addr] = wd;
      got = 1'b0;
      for (int k = 0; k < 5 && !got; k++) begin
        cyc();
        total += 2;
        if ((bus.ram_we & bus.ram_oe) !== 1'b0) begin bad++; $display("FAIL rnd_we_oe op%0d got 1 exp 0", n); end
        if (bus.ram_wdrive !== (bus.ram_cs & bus.ram_we)) begin
          bad++; $display("FAIL rnd_wdrive op%0d got %b exp %b", n, bus.ram_wdrive, bus.ram_cs & bus.ram_we);
        end
        if (we) got = (bus.busy === 1'b0);
        else    got = ((sel ? bus.rvalid_b : bus.rvalid_a) === 1'b1);
      end
      total++;
      if (!got) begin bad++; $display("FAIL rnd_done op%0d got timeout exp completion", n); end
      if (!we) begin
        total++;
        if ((sel ? bus.rdata_b : bus.rdata_a) !== ref_mem[addr]) begin
          bad++; $display("FAIL rnd_rdata op%0d addr %h got %h exp %h", n, addr,
                          sel ? bus.rdata_b : bus.rdata_a, ref_mem[addr]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] <= 8'h00;
      ref_mem[i] = 8'h00;
    end
    rd_reg <= 8'h00;
    test_reset();
    test_write_read();
    test_contention();
    test_back_to_back();
    test_mid_read_reset();
    test_late_request();
    test_random_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "simulation time limit reached");
  end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Arbitrates and sequences port 0 of the synchronous dual-port display RAM between two requesters, A and B (for example, the time-keeping register update logic and the user-configuration logic). Port 1 stays dedicated to the video read path and is not touched by this block. The block grants requesters round-robin and drives registered chip-select, write-enable and output-enable, address and write data. For reads it holds the RAM controls through the RAM's registered-read cycle and returns captured data with a valid pulse.

## Interface
Parameters:
- DATA_WIDTH, 8: RAM word width.
- ADDR_WIDTH, 8: RAM address width.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_a / req_b  in  1  access request; held high until the matching gnt.
- we_a / we_b  in  1  1 = write, 0 = read; held stable while req is high.
- addr_a / addr_b  in  ADDR_WIDTH  access address; held stable while req is high.
- wdata_a / wdata_b  in  DATA_WIDTH  write data; held stable while req is high.
- gnt_a / gnt_b  out  1  one-cycle grant pulse; request fields are latched.
- rdata_a / rdata_b  out  DATA_WIDTH  read result; valid when rvalid is high and held until that requester's next read.
- rvalid_a / rvalid_b  out  1  one-cycle pulse marking read data valid.
- busy  out  1  high in any state other than IDLE.
- ram_cs, ram_we, ram_oe  out  1  RAM port-0 controls, registered.
- ram_addr  out  ADDR_WIDTH  RAM port-0 address, registered.
- ram_wdata  out  DATA_WIDTH  data to be driven onto the RAM port-0 bus.
- ram_wdrive  out  1  tristate enable for ram_wdata; high only during write accesses.
- ram_rdata  in  DATA_WIDTH  RAM port-0 bus as seen by this block.

## Operation
- FSM states: IDLE, ACCESS, HOLD.
- IDLE:
  - With no request pending, all ram_* controls are 0.
  - If one or more requests are pending, pick a winner:
    - With a single request, that requester wins.
    - With both requesting, the requester not marked in the `last` pointer wins.
  - On the edge: assert gnt for the winner; latch we, addr and wdata into ram_*; set ram_cs=1, ram_we=we, ram_oe=~we, ram_wdrive=we; update `last` to the winner; go to ACCESS.
- ACCESS:
  - The RAM performs the write, or loads its read register, at the end of this cycle.
  - gnt drops at the end of ACCESS.
  - For a write: clear all ram_* controls and go to IDLE.
  - For a read: keep ram_cs, ram_oe and ram_addr unchanged and go to HOLD.
- HOLD:
  - The RAM drives its registered data onto the bus.
  - On the edge: capture ram_rdata into rdata of the winner; pulse that requester's rvalid; clear all ram_* controls; go to IDLE.
- `last` resets to B, so A wins the first contention after reset.
- Requester contract:
  - Deassert req in the gnt cycle unless another access is wanted.
  - A req still high in the first IDLE cycle is treated as a new request.
- A write is never combined with a read in the same access, and port 0 is never driven with ram_we=1 and ram_oe=1 together.
- Synchronous reset (reset_n=0 on a rising edge) from any state:
  - go to IDLE;
  - clear all outputs to 0;
  - set `last`=B;
  - drop any in-flight read with no rvalid.
  - A write whose ACCESS cycle coincides with the reset edge may or may not land in RAM; the bench must not check it.

## Timing
- Reset value of every output: 0, with busy=0.
- Request first seen in IDLE at cycle N:
  - gnt_x, ram_cs and busy are high in cycle N+1.
  - A write is committed to RAM at the end of N+1, and the block is back in IDLE at N+2.
  - For a read, HOLD occupies N+2; rvalid_x and rdata_x are valid in N+3, which is also IDLE.
- Throughput:
  - Writes: one access per 2 cycles.
  - Reads: one access per 3 cycles.
- Both requesters held high are served alternately: A, B, A, B…
- Requests arriving during ACCESS or HOLD wait; no grant is issued outside IDLE.

## Test plan
- Single write, then read back:
  - A writes 0x5A to 0x10: gnt_a at N+1 with ram_cs=1, ram_we=1, ram_addr=0x10, ram_wdata=0x5A, ram_wdrive=1; busy low at N+2.
  - B then reads 0x10: rvalid_b at M+3 with rdata_b=0x5A; ram_oe high for exactly 2 cycles.
- Contention from reset: req_a and req_b asserted together, both writes, held high → gnt order A, B, A, B, with grants 2 cycles apart.
- Uncontested back-to-back reads: A issues back-to-back reads of 0x01 and 0x02 (RAM preloaded with 0x11 and 0x22), B idle → rvalid_a pulses 3 cycles apart carrying 0x11 then 0x22.
- Mid-read reset: reset_n low during HOLD of a read by B → next cycle is IDLE, all outputs 0, no rvalid_b. After release, a request from A and B together grants A first.
- Late request: req_b asserted during A's ACCESS → gnt_b appears one cycle after the block returns to IDLE.
- Protocol check: across a random mix of 200 reads and writes, ram_we=1 never coincides with ram_oe=1, ram_wdrive always equals ram_cs & ram_we, and read data matches a reference memory model.
